// File: rtl/as2650_extbus_arb.sv
// Two-master round-robin arbiter and SRAM-style strobe sequencer for the external pad bus.
// Define EXTBUS_LOCK_EN to add m1_lock, which lets the debug master hold the bus across accesses.
module as2650_extbus_arb #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [14:0] m0_addr,
  input  logic [7:0]  m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [7:0]  m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [14:0] m1_addr,
  input  logic [7:0]  m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [7:0]  m1_rdata,
`ifdef EXTBUS_LOCK_EN
  input  logic        m1_lock,
`endif
  output logic [14:0] pad_addr_o,
  output logic [7:0]  pad_data_o,
  input  logic [7:0]  pad_data_i,
  output logic [7:0]  pad_data_oeb,
  output logic        pad_ce_n,
  output logic        pad_oe_n,
  output logic        pad_we_n
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_win;
  logic        r_we;
  logic [3:0]  r_cnt;
  logic        r_m0_gnt;
  logic        r_m1_gnt;
  logic        r_m0_done;
  logic        r_m1_done;
  logic [7:0]  r_m0_rdata;
  logic [7:0]  r_m1_rdata;
  logic [14:0] r_pad_addr;
  logic [7:0]  r_pad_data;
  logic [7:0]  r_pad_oeb;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;

  logic        w_lock;
  logic        w_any;
  logic        w_pick_m1;
  logic        w_we;
  logic [14:0] w_addr;
  logic [7:0]  w_wdata;

  // r_last names the master served most recently; on a tie the other one wins.
  always_comb begin
`ifdef EXTBUS_LOCK_EN
    w_lock = m1_lock & r_last;
`else
    w_lock = 1'b0;
`endif
    w_any     = w_lock ? m1_req : (m0_req | m1_req);
    w_pick_m1 = w_lock | (m1_req & (~m0_req | ~r_last));
    w_we      = w_pick_m1 ? m1_we    : m0_we;
    w_addr    = w_pick_m1 ? m1_addr  : m0_addr;
    w_wdata   = w_pick_m1 ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state    <= S_IDLE;
      r_last     <= 1'b1;
      r_win      <= 1'b0;
      r_we       <= 1'b0;
      r_cnt      <= 4'd0;
      r_m0_gnt   <= 1'b0;
      r_m1_gnt   <= 1'b0;
      r_m0_done  <= 1'b0;
      r_m1_done  <= 1'b0;
      r_m0_rdata <= 8'h00;
      r_m1_rdata <= 8'h00;
      r_pad_addr <= 15'd0;
      r_pad_data <= 8'h00;
      r_pad_oeb  <= 8'hFF;
      r_ce_n     <= 1'b1;
      r_oe_n     <= 1'b1;
      r_we_n     <= 1'b1;
    end else begin
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state    <= S_SETUP;
            r_win      <= w_pick_m1;
            r_last     <= w_pick_m1;
            r_we       <= w_we;
            r_m0_gnt   <= ~w_pick_m1;
            r_m1_gnt   <= w_pick_m1;
            r_pad_addr <= w_addr;
            r_ce_n     <= 1'b0;
            if (w_we) begin
              r_pad_data <= w_wdata;
              r_pad_oeb  <= 8'h00;
            end
          end
        end
        S_SETUP: begin
          r_state <= S_STROBE;
          r_cnt   <= LP_WAIT;
          if (r_we) r_we_n <= 1'b0;
          else      r_oe_n <= 1'b0;
        end
        S_STROBE: begin
          if (r_cnt == 4'd0) begin
            r_state   <= S_HOLD;
            r_oe_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_m0_done <= ~r_win;
            r_m1_done <= r_win;
            // Read data is sampled while OE is still low, on the edge that ends the strobe.
            if (!r_we) begin
              if (r_win) r_m1_rdata <= pad_data_i;
              else       r_m0_rdata <= pad_data_i;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_HOLD: begin
          r_state   <= S_IDLE;
          r_ce_n    <= 1'b1;
          r_pad_oeb <= 8'hFF;
          r_m0_gnt  <= 1'b0;
          r_m1_gnt  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_gnt       = r_m0_gnt;
  assign m1_gnt       = r_m1_gnt;
  assign m0_done      = r_m0_done;
  assign m1_done      = r_m1_done;
  assign m0_rdata     = r_m0_rdata;
  assign m1_rdata     = r_m1_rdata;
  assign pad_addr_o   = r_pad_addr;
  assign pad_data_o   = r_pad_data;
  assign pad_data_oeb = r_pad_oeb;
  assign pad_ce_n     = r_ce_n;
  assign pad_oe_n     = r_oe_n;
  assign pad_we_n     = r_we_n;

endmodule

// File: tb/tb_as2650_extbus_arb.sv
// Bench for as2650_extbus_arb: directed timing checks, then randomized two-master traffic
// scored every cycle against a transaction-phase model of the bus.
module tb_as2650_extbus_arb;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqs   [2];
  logic        wes    [2];
  logic [14:0] addrs  [2];
  logic [7:0]  wdatas [2];
  logic        gnts   [2];
  logic        dones  [2];
  logic [7:0]  rdatas [2];
  logic [14:0] padAddr;
  logic [7:0]  padDataO, padDataI, padOeb;
  logic        padCeN, padOeN, padWeN;
`ifdef EXTBUS_LOCK_EN
  logic        m1Lock;
`endif

  logic        zReq, zWe, zGnt, zDone, zM1Gnt, zM1Done, zCeN, zOeN, zWeN;
  logic [14:0] zAddr, zPadAddr;
  logic [7:0]  zWdata, zPadDataI, zRdata, zM1Rdata, zPadDataO, zPadOeb;

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  bit          mBusy, mWin, mWe, mLast, mFresh, want0, want1;
  int          mPhase;
  logic [14:0] mAddr;
  logic [7:0]  mData;
  logic [7:0]  mRdata [2];
  bit          prevDone [2];

  always #5 clk = ~clk;

  as2650_extbus_arb #(.WAIT_STATES(WS)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_req(reqs[0]), .m0_we(wes[0]), .m0_addr(addrs[0]), .m0_wdata(wdatas[0]),
    .m0_gnt(gnts[0]), .m0_done(dones[0]), .m0_rdata(rdatas[0]),
    .m1_req(reqs[1]), .m1_we(wes[1]), .m1_addr(addrs[1]), .m1_wdata(wdatas[1]),
    .m1_gnt(gnts[1]), .m1_done(dones[1]), .m1_rdata(rdatas[1]),
`ifdef EXTBUS_LOCK_EN
    .m1_lock(m1Lock),
`endif
    .pad_addr_o(padAddr), .pad_data_o(padDataO), .pad_data_i(padDataI),
    .pad_data_oeb(padOeb), .pad_ce_n(padCeN), .pad_oe_n(padOeN), .pad_we_n(padWeN)
  );

  as2650_extbus_arb #(.WAIT_STATES(0)) dutZero (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_req(zReq), .m0_we(zWe), .m0_addr(zAddr), .m0_wdata(zWdata),
    .m0_gnt(zGnt), .m0_done(zDone), .m0_rdata(zRdata),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(15'd0), .m1_wdata(8'h00),
    .m1_gnt(zM1Gnt), .m1_done(zM1Done), .m1_rdata(zM1Rdata),
`ifdef EXTBUS_LOCK_EN
    .m1_lock(1'b0),
`endif
    .pad_addr_o(zPadAddr), .pad_data_o(zPadDataO), .pad_data_i(zPadDataI),
    .pad_data_oeb(zPadOeb), .pad_ce_n(zCeN), .pad_oe_n(zOeN), .pad_we_n(zWeN)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic we,
                               input logic [14:0] addr, input logic [7:0] wdata);
    reqs[m]   = req;
    wes[m]    = we;
    addrs[m]  = addr;
    wdatas[m] = wdata;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic waitDone(output int who);
    who = -1;
    for (int n = 0; n < 40 && who < 0; n++) begin
      tick();
      if (dones[0] === 1'b1) who = 0;
      else if (dones[1] === 1'b1) who = 1;
    end
    checkOutput("wait_done_in_time", 32'(who >= 0), 32'd1);
  endtask

  // Access model: phase 1 is SETUP, 2..WS+2 the strobe, WS+3 the hold cycle with done.
  initial begin
    mBusy = 1'b0; mPhase = 0; mLast = 1'b1; mFresh = 1'b1; mWin = 1'b0; mWe = 1'b0;
    mAddr = '0; mData = '0; mRdata[0] = '0; mRdata[1] = '0;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) prevDone[i] = mBusy && mPhase == WS + 3 && int'(mWin) == i;
      if (rst) begin
        mBusy = 1'b0; mPhase = 0; mLast = 1'b1; mFresh = 1'b1;
        mAddr = '0; mData = '0; mRdata[0] = '0; mRdata[1] = '0;
      end else if (mBusy) begin
        if (mPhase == WS + 2 && !mWe) mRdata[mWin] = padDataI;
        if (mPhase == WS + 3) mBusy = 1'b0;
        else mPhase++;
      end else begin
        want0 = reqs[0];
        want1 = reqs[1];
`ifdef EXTBUS_LOCK_EN
        if (m1Lock && mLast) want0 = 1'b0;
`endif
        if (want0 || want1) begin
          mWin   = (want0 && want1) ? !mLast : want1;
          mLast  = mWin;
          mBusy  = 1'b1;
          mPhase = 1;
          mFresh = 1'b0;
          mWe    = wes[mWin];
          mAddr  = addrs[mWin];
          if (mWe) mData = wdatas[mWin];
        end
      end
    end
  end

  task automatic compareAll();
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("gnt%0d", i), 32'(gnts[i]), 32'(mBusy && int'(mWin) == i));
      checkOutput($sformatf("done%0d", i), 32'(dones[i]),
                  32'(mBusy && mPhase == WS + 3 && int'(mWin) == i));
      checkOutput($sformatf("rdata%0d", i), 32'(rdatas[i]), 32'(mRdata[i]));
    end
    checkOutput("ce_n", 32'(padCeN), 32'(!mBusy));
    checkOutput("oe_n", 32'(padOeN), 32'(!(mBusy && !mWe && mPhase >= 2 && mPhase <= WS + 2)));
    checkOutput("we_n", 32'(padWeN), 32'(!(mBusy && mWe && mPhase >= 2 && mPhase <= WS + 2)));
    checkOutput("oeb", 32'(padOeb), (mBusy && mWe) ? 32'h00 : 32'hFF);
    if (mBusy || mFresh) checkOutput("addr", 32'(padAddr), 32'(mAddr));
    if ((mBusy && mWe) || mFresh) checkOutput("wdata", 32'(padDataO), 32'(mData));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) compareAll();
    end
  end

  initial begin
    int oeLow, weLow, oebLow, oebFirst, oebBad, doneAt, holdOk, setupOk, who;
    logic prevWeN;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) applyStimulus(i, 1'b0, 1'b0, 15'd0, 8'h00);
    padDataI = 8'h00;
    zReq = 1'b0; zWe = 1'b0; zAddr = '0; zWdata = '0; zPadDataI = '0;
`ifdef EXTBUS_LOCK_EN
    m1Lock = 1'b0;
`endif
    tick();
    tick();
    checkEn = 1'b1;
    rst = 1'b0;
    checkOutput("reset_ce_n", 32'(padCeN), 32'd1);
    checkOutput("reset_oeb", 32'(padOeb), 32'hFF);
    checkOutput("reset_rdata0", 32'(rdatas[0]), 32'h00);
    checkOutput("reset_gnt0", 32'(gnts[0]), 32'd0);

    // Single read by m0.
    padDataI = 8'hA5;
    applyStimulus(0, 1'b1, 1'b0, 15'h1234, 8'h00);
    oeLow = 0; doneAt = 0; oebBad = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (padOeN === 1'b0) oeLow++;
      if (padOeb !== 8'hFF) oebBad++;
      if (dones[0] === 1'b1) begin doneAt = k; reqs[0] = 1'b0; end
    end
    checkOutput("read_oe_cycles", 32'(oeLow), 32'd3);
    checkOutput("read_done_cycle", 32'(doneAt), 32'd5);
    checkOutput("read_rdata", 32'(rdatas[0]), 32'hA5);
    checkOutput("read_oeb_driven", 32'(oebBad), 32'd0);

    // Single write by m1.
    applyStimulus(1, 1'b1, 1'b1, 15'h7FFF, 8'h3C);
    oebLow = 0; oebFirst = 0; weLow = 0; holdOk = 0; doneAt = 0; prevWeN = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (padOeb === 8'h00) begin oebLow++; if (oebFirst == 0) oebFirst = k; end
      if (padWeN === 1'b0) weLow++;
      if (prevWeN === 1'b0 && padWeN === 1'b1)
        holdOk = int'(padAddr === 15'h7FFF && padDataO === 8'h3C && padCeN === 1'b0);
      prevWeN = padWeN;
      if (dones[1] === 1'b1) begin doneAt = k; reqs[1] = 1'b0; end
    end
    checkOutput("write_oeb_cycles", 32'(oebLow), 32'd5);
    checkOutput("write_oeb_first", 32'(oebFirst), 32'd1);
    checkOutput("write_we_cycles", 32'(weLow), 32'd3);
    checkOutput("write_hold_stable", 32'(holdOk), 32'd1);
    checkOutput("write_done_cycle", 32'(doneAt), 32'd5);

    // Continuous tie from reset alternates starting with m0.
    applyReset();
    applyStimulus(0, 1'b1, 1'b0, 15'h0100, 8'h00);
    applyStimulus(1, 1'b1, 1'b0, 15'h0200, 8'h00);
    for (int n = 0; n < 4; n++) begin
      waitDone(who);
      checkOutput($sformatf("tie_order%0d", n), 32'(who), 32'(n % 2));
    end
    reqs[0] = 1'b0; reqs[1] = 1'b0;
    tick(); tick();

    // Reset during the strobe of an m0 read: m0 must still win the next tie.
    padDataI = 8'h77;
    applyStimulus(0, 1'b1, 1'b0, 15'h0042, 8'h00);
    tick(); tick();
    rst = 1'b1;
    tick();
    checkOutput("rstmid_ce_n", 32'(padCeN), 32'd1);
    checkOutput("rstmid_oe_n", 32'(padOeN), 32'd1);
    checkOutput("rstmid_we_n", 32'(padWeN), 32'd1);
    checkOutput("rstmid_oeb", 32'(padOeb), 32'hFF);
    checkOutput("rstmid_done0", 32'(dones[0]), 32'd0);
    checkOutput("rstmid_rdata0", 32'(rdatas[0]), 32'h00);
    rst = 1'b0;
    applyStimulus(1, 1'b1, 1'b0, 15'h0043, 8'h00);
    waitDone(who);
    checkOutput("rstmid_first_tie", 32'(who), 32'd0);
    reqs[0] = 1'b0; reqs[1] = 1'b0;
    tick(); tick();

    // Zero wait states: write then read on the second instance.
    zWe = 1'b1; zAddr = 15'h0001; zWdata = 8'h5A; zReq = 1'b1;
    weLow = 0; doneAt = 0; setupOk = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (zWeN === 1'b0) weLow++;
      if (k == 1)
        setupOk = int'(zPadAddr === 15'h0001 && zPadDataO === 8'h5A && zPadOeb === 8'h00
                       && zCeN === 1'b0 && zGnt === 1'b1);
      if (zDone === 1'b1) begin doneAt = k; zReq = 1'b0; end
    end
    checkOutput("ws0_wr_strobe", 32'(weLow), 32'd1);
    checkOutput("ws0_wr_done", 32'(doneAt), 32'd3);
    checkOutput("ws0_wr_setup", 32'(setupOk), 32'd1);
    zWe = 1'b0; zAddr = 15'h0002; zPadDataI = 8'hC3; zReq = 1'b1;
    oeLow = 0; doneAt = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (zOeN === 1'b0) oeLow++;
      if (zDone === 1'b1) begin doneAt = k; zReq = 1'b0; end
    end
    checkOutput("ws0_rd_strobe", 32'(oeLow), 32'd1);
    checkOutput("ws0_rd_done", 32'(doneAt), 32'd3);
    checkOutput("ws0_rd_rdata", 32'(zRdata), 32'hC3);
    checkOutput("ws0_m1_quiet", 32'({zM1Gnt, zM1Done, zM1Rdata}), 32'd0);

`ifdef EXTBUS_LOCK_EN
    // m1 served, then locks: m1 keeps the bus until the lock drops.
    applyStimulus(1, 1'b1, 1'b0, 15'h0300, 8'h00);
    waitDone(who);
    checkOutput("lock_pre", 32'(who), 32'd1);
    m1Lock = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 15'h0301, 8'h00);
    for (int n = 0; n < 3; n++) begin
      waitDone(who);
      checkOutput($sformatf("lock_m1_%0d", n), 32'(who), 32'd1);
    end
    m1Lock = 1'b0;
    waitDone(who);
    checkOutput("lock_release", 32'(who), 32'd0);
    reqs[0] = 1'b0; reqs[1] = 1'b0;
    tick(); tick();
`endif

    // Randomized traffic, including abandoned requests and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      padDataI = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
`ifdef EXTBUS_LOCK_EN
      if ($urandom_range(0, 29) == 0) m1Lock = !m1Lock;
`endif
      for (int i = 0; i < 2; i++) begin
        if (prevDone[i] || reqs[i] !== 1'b1) begin
          if ($urandom_range(0, 2) != 0)
            applyStimulus(i, 1'b1, 1'($urandom_range(0, 1)), 15'($urandom), 8'($urandom));
          else
            reqs[i] = 1'b0;
        end else if ($urandom_range(0, 59) == 0) begin
          reqs[i] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    reqs[0] = 1'b0; reqs[1] = 1'b0;
`ifdef EXTBUS_LOCK_EN
    m1Lock = 1'b0;
`endif
    for (int k = 0; k < 10; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
